fsqrt_bist: RTL and testbench
=============================

# fsqrt_bist

Synthesizable driver/checker for the `fsqrt` unit: the initiating end of its `op1` / `result` / `ready` interface. It generates pseudo-random positive normal single-precision operands and drives them on `op1`. It samples `result` after the unit's latency and checks that `result² ≈ op1` to within a ULP tolerance, counting failures. It sits beside `fsqrt` for on-chip self-test and FPGA bring-up.

## Interface
- `N_VECTORS`, 1000: operands per run (1..65535).
- `LATENCY`, 3: cycles from `op1` update to valid `result` (≥1).
- `TIMEOUT`, 16: extra cycles to wait for `ready` after `LATENCY`.
- `TOL_ULP`, 2: allowed error in ULPs of `result`.
- `SEED`, 32'h1: LFSR seed; 0 is replaced by 1.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle run request.
- `op1`  out  32  operand to `fsqrt`.
- `result`  in  32  root from `fsqrt`.
- `ready`  in  1  `fsqrt` result-valid.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next `start`.
- `pass`  out  1  valid with `done`: `err_count == 0`.
- `err_count`  out  16  failing vectors, saturating at 16'hFFFF.
- `timeout`  out  1  sticky: at least one vector timed out on `ready`.
- `fail_op`  out  32  operand of the first failing vector.

## Operation
- FSM states: IDLE, GEN, WAIT, CHECK, DONE.
- **Reset** (`reset` = 0, any state): state goes to IDLE and LFSR loads the seed. All outputs read 0.
- **IDLE / DONE:** `start` = 1 moves to GEN. It reseeds the LFSR and clears `vec_cnt`, `err_count`, `timeout`, `fail_op`, `done`, `pass`. `start` is ignored in GEN, WAIT and CHECK.
- **LFSR:** 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003). It advances one step per GEN cycle.
- **GEN:** the candidate is `{1'b0, lfsr[30:0]}`.
  - Exponent of 0 or 255: rejected. Stay in GEN; the vector is not counted.
  - Otherwise: register the candidate on `op1`, clear `wcnt`, go to WAIT.
- **WAIT:** `wcnt` increments each cycle.
  - `wcnt == LATENCY-1` and `ready` = 1: go to CHECK.
  - `wcnt == LATENCY-1+TIMEOUT` and `ready` = 0: mark the vector failed, set `timeout`, go to CHECK.
- **CHECK** (one cycle): evaluate the vector, increment `vec_cnt`. Go to DONE if `vec_cnt` reaches `N_VECTORS`, else GEN.
- `op1` is held stable from its GEN update through CHECK.
- **Check arithmetic** (`op1` has exponent `Ex`, mantissa `mx`; `result` has sign `s`, exponent `Er`, mantissa `mr`):
  - `e = Ex - 127` (signed). Expected exponent `Ee = (e >>> 1) + 127`. `k = e & 1`.
  - `X = {1'b1, mx} << k` (25 bits, 23 fraction bits).
  - `R = {1'b1, mr}` when `Er == Ee`. `R = 25'h1000000` (2.0) when `Er == Ee+1` and `mr == 0`. Any other `Er`, or `s` = 1, fails.
  - `D = |R*R - (X << 23)|`, a 50-bit unsigned value with 46 fraction bits.
  - Pass iff `D <= TOL_ULP << 25`. One ULP of `R` perturbs `R²` by less than 4·2^-23.
- **On failure:** `err_count` increments (saturating). `fail_op` is captured only if it is the first failure of the run.
- **DONE:** `busy` = 0, `done` = 1, `pass` = (`err_count == 0`).

## Timing
- **`start`:** sampled high at edge T0 → `busy` = 1 from T0.
- **`op1`:** updates at the GEN edge G, which is the first valid candidate.
  - Nominal case: `result` is sampled at edge G+LATENCY, provided `ready` = 1.
  - CHECK completes at edge G+LATENCY+1.
  - The next GEN is evaluated in the following cycle.
- **Cycles per vector:** `LATENCY + 2` when the LFSR candidate is valid, plus 1 per rejected candidate.
- **Run end:** `done` and `pass` rise on the same edge `busy` falls.
- **Ordering:** `err_count` / `fail_op` are updated at the CHECK edge and are never visible before `done` in a different order.
- **Reset mid-run:** takes effect immediately (asynchronous). After reset is released, a new `start` reproduces the identical `op1` sequence.

## Test plan
- **Reset:** hold `reset` = 0 mid-run with outputs nonzero → `op1` = 0, `busy` = `done` = `pass` = `timeout` = 0, `err_count` = 0, `fail_op` = 0 within the same cycle.
- **Ideal model:** exact round-to-nearest sqrt, `LATENCY` = 3, `ready` tied 1, `N_VECTORS` = 1000 →
  - every `op1` has sign 0 and exponent in 1..254;
  - per-vector spacing is 5 cycles plus rejections;
  - `done` = 1, `pass` = 1, `err_count` = 0.
- **Single fault:** model adds +3 ULP to `result` on the 6th vector only (`TOL_ULP` = 2) → `err_count` = 1, `fail_op` = 6th `op1`, `pass` = 0.
- **Timeout:** `ready` stuck 0, `N_VECTORS` = 4 → each vector spends `LATENCY + TIMEOUT` = 19 WAIT cycles; `err_count` = 4, `timeout` = 1, `done` = 1.
- **Rounding edge:** model returns 32'h40000000 for `op1` = 32'h407FFFFF (injected via a test-only override of the candidate) → counted as pass.
- **Start / reset sequencing:**
  - `start` pulsed while `busy` → ignored; no counter change.
  - `start` in DONE → counters cleared and the `op1` sequence repeats from the seed.
  - Reset at cycle 50 followed by `start` → the same first 10 operands as the original run.

Source files
------------

// File: rtl/fsqrt_bist_if.sv
// fsqrt_bist_if: operand/result link between the self-test driver and fsqrt.
// The master drives op1 and samples result when ready is high.
interface fsqrt_bist_if;
    logic [31:0] op1;
    logic [31:0] result;
    logic        ready;

    modport master (
        output op1,
        input  result,
        input  ready
    );

    modport slave (
        input  op1,
        output result,
        output ready
    );
endinterface

// File: rtl/fsqrt_bist.sv
// fsqrt_bist: on-chip driver/checker for fsqrt.
// Feeds random positive normal operands and checks result^2 ~= op1.
module fsqrt_bist #(
    parameter int          N_VECTORS = 1000,
    parameter int          LATENCY   = 3,
    parameter int          TIMEOUT   = 16,
    parameter int          TOL_ULP   = 2,
    parameter logic [31:0] SEED      = 32'h1,
    parameter logic [31:0] FORCE_OP  = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fsqrt_bist_if.master        fs,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic                timeout,
    output logic [31:0]         fail_op
);

    typedef enum logic [2:0] {IDLE, GEN, WAIT, CHECK, DONE} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0] W_RDY     = 16'(LATENCY - 1);
    localparam logic [15:0] W_TMO     = 16'(LATENCY - 1 + TIMEOUT);
    localparam logic [15:0] N_VEC     = 16'(N_VECTORS);
    localparam logic [49:0] TOL_D     = 50'(TOL_ULP) << 25;

    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] res_q, res_d;
    logic [31:0] fail_op_q, fail_op_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [15:0] vec_q, vec_d;
    logic [15:0] err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        timeout_q, timeout_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        busy_q, busy_d;

    logic [31:0] lfsr_nx;
    logic [31:0] cand;
    logic        cand_ok;

    always_comb begin
        lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        // A nonzero FORCE_OP pins every candidate to one operand.
        cand    = (FORCE_OP != 32'h0) ? FORCE_OP : {1'b0, lfsr_q[30:0]};
        cand_ok = (cand[30:23] != 8'h00) && (cand[30:23] != 8'hFF);
    end

    logic signed [9:0] e_un;
    logic signed [9:0] e_half;
    logic [7:0]        ee;
    logic [24:0]       x_m;
    logic [24:0]       r_m;
    logic              r_ok;
    logic [49:0]       rr;
    logic [49:0]       xx;
    logic [49:0]       diff;
    logic              vec_ok;

    // Compare R^2 with the operand significand, both with 46 fraction bits.
    always_comb begin
        e_un   = $signed({2'b00, op1_q[30:23]}) - 10'sd127;
        e_half = e_un >>> 1;
        ee     = 8'(e_half + 10'sd127);
        x_m    = {2'b01, op1_q[22:0]} << e_un[0];
        r_ok   = 1'b1;
        r_m    = {2'b01, res_q[22:0]};
        if (res_q[31]) begin
            r_ok = 1'b0;
        end else if (res_q[30:23] == ee) begin
            r_m = {2'b01, res_q[22:0]};
        end else if ((res_q[30:23] == ee + 8'd1) && (res_q[22:0] == 23'd0)) begin
            r_m = 25'h1000000;
        end else begin
            r_ok = 1'b0;
        end
        rr     = 50'(r_m) * 50'(r_m);
        xx     = {2'b00, x_m, 23'd0};
        diff   = (rr >= xx) ? (rr - xx) : (xx - rr);
        vec_ok = r_ok && !tmo_q && (diff <= TOL_D);
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        op1_d     = op1_q;
        res_d     = res_q;
        fail_op_d = fail_op_q;
        wcnt_d    = wcnt_q;
        vec_d     = vec_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
        done_d    = done_q;
        pass_d    = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = GEN;
                    lfsr_d    = SEED_EFF;
                    vec_d     = 16'd0;
                    err_d     = 16'd0;
                    timeout_d = 1'b0;
                    fail_op_d = 32'd0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            GEN: begin
                lfsr_d = lfsr_nx;
                if (cand_ok) begin
                    op1_d   = cand;
                    wcnt_d  = 16'd0;
                    tmo_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if ((wcnt_q == W_RDY) && fs.ready) begin
                    res_d   = fs.result;
                    state_d = CHECK;
                end else if (wcnt_q >= W_TMO) begin
                    tmo_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = CHECK;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            CHECK: begin
                vec_d = vec_q + 16'd1;
                if (!vec_ok) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'd0) begin
                        fail_op_d = op1_q;
                    end
                end
                if (vec_d == N_VEC) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 16'd0);
                end else begin
                    state_d = GEN;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == GEN) || (state_d == WAIT) || (state_d == CHECK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            op1_q     <= 32'd0;
            res_q     <= 32'd0;
            fail_op_q <= 32'd0;
            wcnt_q    <= 16'd0;
            vec_q     <= 16'd0;
            err_q     <= 16'd0;
            tmo_q     <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            op1_q     <= op1_d;
            res_q     <= res_d;
            fail_op_q <= fail_op_d;
            wcnt_q    <= wcnt_d;
            vec_q     <= vec_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
        end
    end

    assign fs.op1    = op1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign timeout   = timeout_q;
    assign fail_op   = fail_op_q;

endmodule

// File: tb/tb_fsqrt_bist.sv
// tb_fsqrt_bist: directed bench for fsqrt_bist with an fsqrt model,
// an LFSR reference and a verdict queue per vector.
module tb_fsqrt_bist;
    localparam int          LAT    = 3;
    localparam int          TMO    = 16;
    localparam int          TOL    = 2;
    localparam int          NV     = 1000;
    localparam int          NT     = 4;
    localparam logic [31:0] MASK   = 32'h80200003;
    localparam logic [31:0] RND_OP = 32'h407FFFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_start = 1'b0;
    logic t_start = 1'b0;
    logic r_start = 1'b0;

    logic        m_busy, m_done, m_pass, m_tmo;
    logic [15:0] m_err;
    logic [31:0] m_fop;
    logic        t_busy, t_done, t_pass, t_tmo;
    logic [15:0] t_err;
    logic [31:0] t_fop;
    logic        r_busy, r_done, r_pass, r_tmo;
    logic [15:0] r_err;
    logic [31:0] r_fop;

    fsqrt_bist_if m_if ();
    fsqrt_bist_if t_if ();
    fsqrt_bist_if r_if ();

    fsqrt_bist #(.N_VECTORS(NV), .LATENCY(LAT), .TIMEOUT(TMO), .TOL_ULP(TOL)) u_main (
        .clk(clk), .reset(rst_n), .start(m_start), .fs(m_if),
        .busy(m_busy), .done(m_done), .pass(m_pass), .err_count(m_err),
        .timeout(m_tmo), .fail_op(m_fop)
    );

    fsqrt_bist #(.N_VECTORS(NT), .LATENCY(LAT), .TIMEOUT(TMO), .TOL_ULP(TOL)) u_to (
        .clk(clk), .reset(rst_n), .start(t_start), .fs(t_if),
        .busy(t_busy), .done(t_done), .pass(t_pass), .err_count(t_err),
        .timeout(t_tmo), .fail_op(t_fop)
    );

    fsqrt_bist #(.N_VECTORS(1), .LATENCY(LAT), .TIMEOUT(TMO), .TOL_ULP(TOL),
                 .FORCE_OP(RND_OP)) u_rnd (
        .clk(clk), .reset(rst_n), .start(r_start), .fs(r_if),
        .busy(r_busy), .done(r_done), .pass(r_pass), .err_count(r_err),
        .timeout(r_tmo), .fail_op(r_fop)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    bit          exp_q[$];
    logic [31:0] first_ops[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
    endfunction

    task automatic next_op(inout logic [31:0] s, output logic [31:0] op, output int rej);
        rej = 0;
        op  = {1'b0, s[30:0]};
        s   = lfsr_step(s);
        while ((op[30:23] == 8'h00 || op[30:23] == 8'hFF) && rej < 1000) begin
            rej++;
            op = {1'b0, s[30:0]};
            s  = lfsr_step(s);
        end
    endtask

    // Round-to-nearest square root by integer bisection of the significand.
    function automatic logic [31:0] sqrt_rne(input logic [31:0] a);
        int          e;
        int          ee;
        logic [63:0] n;
        logic [63:0] q;
        logic [63:0] b;
        logic [63:0] r;
        e  = int'(a[30:23]) - 127;
        ee = (e >>> 1) + 127;
        n  = {40'd0, 1'b1, a[22:0]} << (25 + (e & 1));
        q  = 64'd0;
        for (int i = 25; i >= 0; i--) begin
            b = q | (64'd1 << i);
            if (b * b <= n) q = b;
        end
        r = (q + 64'd1) >> 1;
        if (r[24]) begin
            ee = ee + 1;
            r  = 64'd0;
        end
        return {1'b0, 8'(ee), r[22:0]};
    endfunction

    function automatic bit real_ok(input logic [31:0] a, input logic [31:0] r);
        int  e;
        int  ee;
        int  er;
        real x;
        real rv;
        real d;
        e  = int'(a[30:23]) - 127;
        ee = (e >>> 1) + 127;
        x  = (1.0 + real'(a[22:0]) / 8388608.0) * (((e & 1) != 0) ? 2.0 : 1.0);
        er = int'(r[30:23]);
        if (r[31]) return 1'b0;
        if (er == ee) rv = 1.0 + real'(r[22:0]) / 8388608.0;
        else if (er == ee + 1 && r[22:0] == 23'd0) rv = 2.0;
        else return 1'b0;
        d = rv * rv - x;
        if (d < 0.0) d = -d;
        return d <= real'(TOL) / 2097152.0;
    endfunction

    task automatic run_main(input bit fault, input int pulse_at, input int nvec,
                            input bit record, input bit cmp_first);
        logic [31:0] s;
        logic [31:0] op;
        logic [31:0] prev;
        logic [31:0] fop;
        logic [31:0] res;
        int          rej;
        int          errs;
        bit          ok;
        s    = 32'h1;
        errs = 0;
        fop  = 32'd0;
        prev = 32'd0;
        exp_q.delete();
        @(negedge clk) m_start = 1'b1;
        @(negedge clk) m_start = 1'b0;
        chk("start_busy", 32'(m_busy), 32'd1);
        chk("start_done_clr", 32'(m_done), 32'd0);
        chk("start_err_clr", 32'(m_err), 32'd0);
        chk("start_fop_clr", m_fop, 32'd0);
        for (int i = 0; i < nvec; i++) begin
            next_op(s, op, rej);
            repeat (rej) @(negedge clk);
            if (i > 0) chk("op1_hold", m_if.op1, prev);
            @(negedge clk);
            chk("op1_seq", m_if.op1, op);
            chk("op1_range", 32'(m_if.op1[31] == 1'b0 && m_if.op1[30:23] != 8'h00
                                 && m_if.op1[30:23] != 8'hFF), 32'd1);
            if (record) first_ops.push_back(op);
            if (cmp_first && i < first_ops.size()) chk("op1_repeat", m_if.op1, first_ops[i]);
            res = sqrt_rne(op);
            if (fault && i == 5) res = res + 32'd3;
            m_if.result = res;
            exp_q.push_back(real_ok(op, res));
            for (int c = 0; c < LAT + 1; c++) begin
                @(negedge clk);
                if (i == pulse_at) m_start = (c == 0);
            end
            ok = exp_q.pop_front();
            if (!ok) begin
                if (errs == 0) fop = op;
                errs++;
            end
            chk("err_count", 32'(m_err), 32'(errs));
            prev = op;
        end
        if (nvec == NV) begin
            chk("run_done", 32'(m_done), 32'd1);
            chk("run_busy", 32'(m_busy), 32'd0);
            chk("run_pass", 32'(m_pass), 32'(errs == 0));
            chk("run_fail_op", m_fop, fop);
            chk("run_timeout", 32'(m_tmo), 32'd0);
            if (!fault) chk("ideal_pass", 32'(m_pass), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] op;
        logic [31:0] t_first;
        logic [31:0] t_last;
        int          rej;
        int          total;
        int          two;
        m_if.result = 32'd0;
        m_if.ready  = 1'b1;
        t_if.result = 32'd0;
        t_if.ready  = 1'b0;
        r_if.result = 32'h40000000;
        r_if.ready  = 1'b1;

        #12;
        chk("rst_op1", m_if.op1, 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_pass", 32'(m_pass), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_tmo", 32'(m_tmo), 32'd0);
        chk("rst_fop", m_fop, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        s = 32'h1;
        two = 0;
        for (int i = 0; i < 2; i++) begin
            next_op(s, op, rej);
            two += rej + LAT + TMO + 2;
        end
        @(negedge clk) t_start = 1'b1;
        @(negedge clk) t_start = 1'b0;
        repeat (two + 3) @(negedge clk);
        chk("mid_busy", 32'(t_busy), 32'd1);
        chk("mid_err", 32'(t_err), 32'd2);
        chk("mid_tmo", 32'(t_tmo), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_op1", t_if.op1, 32'd0);
        chk("arst_busy", 32'(t_busy), 32'd0);
        chk("arst_done", 32'(t_done), 32'd0);
        chk("arst_pass", 32'(t_pass), 32'd0);
        chk("arst_err", 32'(t_err), 32'd0);
        chk("arst_tmo", 32'(t_tmo), 32'd0);
        chk("arst_fop", t_fop, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        s = 32'h1;
        total = 0;
        t_first = 32'd0;
        t_last = 32'd0;
        for (int i = 0; i < NT; i++) begin
            next_op(s, op, rej);
            total += rej + LAT + TMO + 2;
            if (i == 0) t_first = op;
            t_last = op;
        end
        @(negedge clk) t_start = 1'b1;
        @(negedge clk) t_start = 1'b0;
        repeat (total - 1) @(negedge clk);
        chk("to_done_early", 32'(t_done), 32'd0);
        @(negedge clk);
        chk("to_done", 32'(t_done), 32'd1);
        chk("to_busy", 32'(t_busy), 32'd0);
        chk("to_err", 32'(t_err), 32'(NT));
        chk("to_tmo", 32'(t_tmo), 32'd1);
        chk("to_pass", 32'(t_pass), 32'd0);
        chk("to_fop", t_fop, t_first);
        chk("to_op1", t_if.op1, t_last);

        @(negedge clk) r_start = 1'b1;
        @(negedge clk) r_start = 1'b0;
        @(negedge clk);
        chk("rnd_op1", r_if.op1, RND_OP);
        repeat (LAT) @(negedge clk);
        chk("rnd_done_early", 32'(r_done), 32'd0);
        @(negedge clk);
        chk("rnd_done", 32'(r_done), 32'd1);
        chk("rnd_pass", 32'(r_pass), 32'd1);
        chk("rnd_err", 32'(r_err), 32'd0);

        run_main(1'b1, 10, NV, 1'b1, 1'b0);
        run_main(1'b0, -1, NV, 1'b0, 1'b1);

        @(negedge clk) m_start = 1'b1;
        @(negedge clk) m_start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("r50_busy", 32'(m_busy), 32'd0);
        chk("r50_op1", m_if.op1, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_main(1'b0, -1, 10, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
